argmax_sequencer: RTL
=====================

# argmax_sequencer

Sequential classifier back end placed after the fully-connected output layer. It accepts one frame of `NUM_CLASSES` signed class scores, streamed one score per handshake, and reduces them with a single shared comparator to the winning class index and its score. It returns the result over a valid/ready handshake and latches the winning digit onto a 7-segment display.

## Interface
- `NUM_CLASSES`, default 10: scores per frame; legal range 2..16.
- `SCORE_WIDTH`, default 16: signed two's-complement score width.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low; clock `clock`.
- `start` in 1: begin a frame; sampled only in IDLE.
- `abort` in 1: discard the frame in progress; returns to IDLE.
- `score_valid` in 1: `score_data` is valid.
- `score_ready` out 1: block accepts a score this cycle.
- `score_data` in `SCORE_WIDTH`: signed class score; class index is implicit from arrival order, 0 first.
- `result_valid` out 1: result is available.
- `result_ready` in 1: consumer takes the result.
- `result_class` out 4: winning class index.
- `result_score` out `SCORE_WIDTH`: winning score.
- `busy` out 1: high in COLLECT or HOLD.
- `hex` out 7: active-low segments {g,f,e,d,c,b,a} for the last delivered class.

## Operation
- States:
  - IDLE: `score_ready`=0, `result_valid`=0. `start`=1 → COLLECT, with idx←0.
  - COLLECT: `score_ready`=1. A score is accepted when `score_valid` && `score_ready`.
    - Accept at idx=0: max←score, arg←0.
    - Accept at idx>0: replace max/arg only if score > max (signed, strict).
    - idx increments on every accept.
    - The accept at idx=NUM_CLASSES-1 → HOLD.
  - HOLD: `result_valid`=1, `score_ready`=0. `result_ready`=1 → IDLE.
- Tie-break: the lowest index wins, because only strictly greater scores replace the max. If all scores are equal, the result is class 0.
- All comparisons are signed at full `SCORE_WIDTH`; no saturation or truncation.
- idx counter is 4 bits and never wraps inside a frame.
- `abort`=1 in COLLECT or HOLD → IDLE next edge. The partial max is discarded, no result is produced and `hex` is unchanged. `abort` has priority over accept and over `result_ready`.
- `start` outside IDLE is ignored. `start` and `abort` both high in IDLE: `abort` wins and the block stays in IDLE.
- `result_class`/`result_score` are stable for the whole of HOLD and keep their values after leaving HOLD until the next frame completes.
- `hex` is loaded on the result handshake edge (HOLD && `result_ready`) from `result_class`:
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001
  - 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0011000
  - 10..15 0000110 ("E").

## Timing
- Reset values: state IDLE, `score_ready`=0, `result_valid`=0, `busy`=0, `result_class`=0, `result_score`=0, `hex`=7'b1110111. Reset asserted mid-frame clears all state immediately (asynchronous).
- Edge N: `start` sampled in IDLE. From N+1: `score_ready`=1 and `busy`=1.
- With no stalls, scores are accepted on edges N+1..N+NUM_CLASSES.
- `result_valid` rises the cycle after the last accept. Minimum start-to-result latency is NUM_CLASSES+1 cycles.
- Bubbles on `score_valid` stretch COLLECT and do not change the result.
- `result_ready` high at edge M in HOLD: `result_valid`=0 and `hex` updated from M+1.
- A new `start` is accepted no earlier than M+1, giving back-to-back frames of NUM_CLASSES+2 cycles.
- `score_ready` is a registered state decode only, with no combinational path from `score_valid`. `result_valid` is registered.

## Test plan
- Scores 3,-1,7,2,0,5,7,-8,1,4 with no stalls → `result_class`=2, `result_score`=7, `result_valid` at start+11, `hex`=0100100 after the handshake.
- All ten scores = -5 → class 0, score -5, `hex`=1000000. Scores -32768 ×9 then -32767 at index 9 → class 9, `hex`=0011000.
- Random `score_valid` gaps plus `result_ready` held low 20 cycles → result values stable throughout HOLD, `hex` unchanged until the handshake, then `busy`=0.
- `abort` after 4 accepts, then a full frame with max at index 6 → only class 6 reported, no spurious `result_valid`, `hex` stays at the previous value until the second handshake.
- `reset` low for 1 cycle after 5 accepts → all outputs at reset values immediately. The next frame's result is independent of the pre-reset scores.
- `start` pulsed during COLLECT and HOLD, and `start`+`abort` together in IDLE → no state change; frame index count verified.

Source files
------------

// File: rtl/argmax_sequencer.sv
// argmax_sequencer: streams NUM_CLASSES signed scores through one shared
// comparator, reports the winning class/score over valid/ready and latches
// the delivered class onto an active-low 7-segment display.
module argmax_sequencer #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   score_valid,
  output logic                   score_ready,
  input  logic [SCORE_WIDTH-1:0] score_data,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [3:0]             result_class,
  output logic [SCORE_WIDTH-1:0] result_score,
  output logic                   busy,
  output logic [6:0]             hex
);

  localparam logic [3:0] LAST_IDX  = 4'(NUM_CLASSES - 1);
  localparam logic [6:0] HEX_RESET = 7'b1110111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                         state_q;
  logic   [3:0]                   idx_q;
  logic   signed [SCORE_WIDTH-1:0] max_q;
  logic   [3:0]                   arg_q;
  logic   [3:0]                   result_class_q;
  logic   [SCORE_WIDTH-1:0]       result_score_q;
  logic   [6:0]                   hex_q;
  logic                           score_ready_q;
  logic                           result_valid_q;
  logic                           busy_q;

  logic                           accept;
  logic                           take_d;
  logic   signed [SCORE_WIDTH-1:0] max_d;
  logic   [3:0]                   arg_d;

  // Active-low {g,f,e,d,c,b,a} digit patterns; 10..15 show "E".
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0011000;
      default: seg = 7'b0000110;
    endcase
    return seg;
  endfunction

  // Shared comparator: first score seeds the max, later ones replace it only
  // when strictly greater, so ties keep the lowest index.
  always_comb begin
    accept = 1'b0;
    take_d = 1'b0;
    max_d  = max_q;
    arg_d  = arg_q;
    accept = (state_q == COLLECT) && score_valid && !abort;
    take_d = (idx_q == '0) || ($signed(score_data) > max_q);
    if (take_d) begin
      max_d = $signed(score_data);
      arg_d = idx_q;
    end
  end

  // Frame FSM with registered handshake, status, result and display outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      max_q          <= '0;
      arg_q          <= '0;
      result_class_q <= '0;
      result_score_q <= '0;
      hex_q          <= HEX_RESET;
      score_ready_q  <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q       <= COLLECT;
            idx_q         <= '0;
            score_ready_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        COLLECT: begin
          if (abort) begin
            state_q       <= IDLE;
            score_ready_q <= 1'b0;
            busy_q        <= 1'b0;
          end else if (accept) begin
            max_q <= max_d;
            arg_q <= arg_d;
            idx_q <= idx_q + 4'd1;
            if (idx_q == LAST_IDX) begin
              // Result registers take the final comparison directly so they
              // only change when a frame actually completes.
              state_q        <= HOLD;
              score_ready_q  <= 1'b0;
              result_valid_q <= 1'b1;
              result_class_q <= arg_d;
              result_score_q <= max_d;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end else if (result_ready) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            hex_q          <= seg7(result_class_q);
          end
        end
        default: begin
          state_q        <= IDLE;
          score_ready_q  <= 1'b0;
          result_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign score_ready  = score_ready_q;
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign result_score = result_score_q;
  assign busy         = busy_q;
  assign hex          = hex_q;

endmodule
